// File: rtl/module_event_packer.sv
`timescale 1ns/1ps
// module_event_packer
// Buffers the decoder's qualified words in a first-word-fall-through FIFO,
// appends one trailer word when the decoder's running flag falls, and
// presents the stream to the readout arbiter.
// Build option: define PACKER_TIMESTAMP_EN to emit a timestamp word
// {3'b011, 1'b1, ts[11:0]} ahead of every trailer.
//
// Handshake: a word transfers on a clk80 edge where dout_valid and
// dout_ready are both high; while dout_valid=1 and dout_ready=0 the
// outputs dout/dout_valid hold their values.
module module_event_packer #(
    parameter int AW   = 5,
    parameter int CNTW = 9
) (
    input  logic        clk80,
    input  logic        reset,
    input  logic        running,
    input  logic        write,
    input  logic [15:0] data,
    input  logic [1:0]  err,
    output logic [15:0] dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        overflow,
    output logic [15:0] evt_count,
    output logic [1:0]  state_dbg
);

    localparam int DEPTH = 1 << AW;
`ifdef PACKER_TIMESTAMP_EN
    localparam int RSV = 2;
    typedef enum logic [1:0] {IDLE = 2'd0, EVENT = 2'd1, TRAIL = 2'd2, TS = 2'd3} state_t;
`else
    localparam int RSV = 1;
    typedef enum logic [1:0] {IDLE = 2'd0, EVENT = 2'd1, TRAIL = 2'd2} state_t;
`endif
    // Data words may only fill up to DEPTH-RSV so the closing words always fit.
    localparam logic [AW:0] DATA_LIM = (AW+1)'(DEPTH - RSV);
    localparam logic [AW:0] FULL_LIM = (AW+1)'(DEPTH);

    state_t          state_q, state_d;
    logic            run_d, rise, fall;
    logic            rise_pend;
    logic [CNTW-1:0] wcnt;
    logic [1:0]      err_acc;
    logic            ev_ovf, ovf_q;
    logic [15:0]     evt_q;

    logic [15:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     mem_used, used;
    logic [15:0]     dout_q;
    logic            valid_q;

    logic            push_trl, push_ts, push_data, drop, push, pop, load;
    logic [15:0]     push_word, trailer_word;

    assign rise = running & ~run_d;
    assign fall = ~running & run_d;

    // Occupancy seen by pushes: words in memory plus the word on dout,
    // always taken before this cycle's pop.
    assign used = mem_used + (AW+1)'(valid_q);

    // A closing word owns the write port; a coincident data word is dropped.
    assign push_data = write & ~push_trl & ~push_ts & (used < DATA_LIM);
    assign drop      = write & ~push_data;
    assign push      = push_data | push_trl | push_ts;
    assign pop       = valid_q & dout_ready;
    // Refill the output register whenever it is empty or being consumed.
    assign load      = (mem_used != '0) & (~valid_q | pop);

    assign trailer_word = {3'b011, 1'b0, ev_ovf, err_acc, wcnt};

`ifdef PACKER_TIMESTAMP_EN
    logic [11:0] ts_ctr, ts_evt, ts_pend;
    logic        ts_pend_v;
    logic [15:0] ts_word;
    logic        rise_in_ts;

    assign ts_word    = {3'b011, 1'b1, ts_evt};
    // A new event starting while the old timestamp is still queued must not
    // overwrite it; park the new value until the timestamp word is pushed.
    assign rise_in_ts = rise & (state_q == TS) & ~push_ts;
    assign push_word  = push_trl ? trailer_word : (push_ts ? ts_word : data);

    // Free-running timestamp and per-event latch.
    always_ff @(posedge clk80 or posedge reset) begin
        if (reset) begin
            ts_ctr    <= '0;
            ts_evt    <= '0;
            ts_pend   <= '0;
            ts_pend_v <= 1'b0;
        end else begin
            ts_ctr <= ts_ctr + 12'd1;
            if (rise && !rise_in_ts)
                ts_evt <= ts_ctr;
            else if (push_ts && ts_pend_v)
                ts_evt <= ts_pend;
            if (rise_in_ts) begin
                ts_pend   <= ts_ctr;
                ts_pend_v <= 1'b1;
            end else if (push_ts) begin
                ts_pend_v <= 1'b0;
            end
        end
    end
`else
    assign push_word = push_trl ? trailer_word : data;
`endif

    // State register and running-edge detector.
    always_ff @(posedge clk80 or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            run_d   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_d   <= running;
        end
    end

    // Next-state logic and closing-word push requests.
    always_comb begin
        state_d  = state_q;
        push_trl = 1'b0;
        push_ts  = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) state_d = EVENT;
            end
            EVENT: begin
`ifdef PACKER_TIMESTAMP_EN
                if (fall) state_d = TS;
`else
                if (fall) state_d = TRAIL;
`endif
            end
`ifdef PACKER_TIMESTAMP_EN
            TS: begin
                if (used < FULL_LIM) begin
                    push_ts = 1'b1;
                    state_d = TRAIL;
                end
            end
`endif
            TRAIL: begin
                if (used < FULL_LIM) begin
                    push_trl = 1'b1;
                    state_d  = (rise | rise_pend) ? EVENT : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Per-event bookkeeping. Counting restarts at the trailer push so that
    // writes seen between events belong to the next trailer.
    always_ff @(posedge clk80 or posedge reset) begin
        if (reset) begin
            wcnt      <= '0;
            err_acc   <= 2'b00;
            ev_ovf    <= 1'b0;
            rise_pend <= 1'b0;
            ovf_q     <= 1'b0;
            evt_q     <= 16'd0;
        end else begin
            if (push_trl) begin
                wcnt      <= write ? CNTW'(1) : '0;
                err_acc   <= 2'b00;
                ev_ovf    <= drop;
                rise_pend <= 1'b0;
                evt_q     <= evt_q + 16'd1;
            end else begin
                if (write && (wcnt != '1)) wcnt <= wcnt + CNTW'(1);
                if (state_q == EVENT) err_acc <= err_acc | err;
                if (drop) ev_ovf <= 1'b1;
                if (rise && (state_q != IDLE) && (state_q != EVENT)) rise_pend <= 1'b1;
            end
            if (drop) ovf_q <= 1'b1;
        end
    end

    // FIFO storage; no reset needed on the data array.
    always_ff @(posedge clk80) begin
        if (push) mem[wr_ptr] <= push_word;
    end

    // FIFO pointers, occupancy and registered head word.
    always_ff @(posedge clk80 or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            mem_used <= '0;
            dout_q   <= 16'd0;
            valid_q  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (load) begin
                dout_q <= mem[rd_ptr];
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, load})
                2'b10:   mem_used <= mem_used + (AW+1)'(1);
                2'b01:   mem_used <= mem_used - (AW+1)'(1);
                default: mem_used <= mem_used;
            endcase
            if (load)
                valid_q <= 1'b1;
            else if (pop)
                valid_q <= 1'b0;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign overflow   = ovf_q;
    assign evt_count  = evt_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_module_event_packer.sv
`timescale 1ns/1ps
// Directed bench for module_event_packer: expected words are queued as the
// stimulus is driven and compared as the output stream delivers them.
module tb_module_event_packer;

    logic        clk80 = 1'b0;
    logic        reset;
    logic        running;
    logic        write;
    logic [15:0] data;
    logic [1:0]  err;
    logic [15:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        overflow;
    logic [15:0] evt_count;
    logic [1:0]  state_dbg;

    logic [15:0] exp_q[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          n_pop    = 0;
    logic        hold_v   = 1'b0;
    logic [15:0] hold_w   = 16'd0;
    logic [11:0] ev_ts    = 12'd0;

`ifdef PACKER_TIMESTAMP_EN
    localparam int KEEP = 30;
    int ts_cyc;
    always @(posedge clk80 or posedge reset) begin
        if (reset) ts_cyc <= 0;
        else       ts_cyc <= ts_cyc + 1;
    end
`else
    localparam int KEEP = 31;
`endif

    module_event_packer dut (
        .clk80      (clk80),
        .reset      (reset),
        .running    (running),
        .write      (write),
        .data       (data),
        .err        (err),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .overflow   (overflow),
        .evt_count  (evt_count),
        .state_dbg  (state_dbg)
    );

    // Clock: 80 MHz.
    always #6.25 clk80 = ~clk80;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then advance past the next rising edge.
    task automatic step(input logic r, input logic w, input logic [15:0] d, input logic [1:0] e);
        running = r;
        write   = w;
        data    = d;
        err     = e;
        @(posedge clk80);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'd0, 2'b00);
    endtask

    // First cycle of an event; remembers the timestamp the DUT will latch.
    task automatic begin_event();
`ifdef PACKER_TIMESTAMP_EN
        ev_ts = ts_cyc[11:0];
`endif
        step(1'b1, 1'b0, 16'd0, 2'b00);
    endtask

    task automatic write_word(input logic [15:0] d, input logic keep);
        if (keep) exp_q.push_back(d);
        step(1'b1, 1'b1, d, 2'b00);
    endtask

    task automatic expect_trailer(input logic [15:0] tr);
`ifdef PACKER_TIMESTAMP_EN
        exp_q.push_back({4'b0111, ev_ts});
`endif
        exp_q.push_back(tr);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) idle(1);
        n_assert++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL %s: observed %0d words left expected 0", tag, exp_q.size());
        end
        exp_q.delete();
    endtask

    // Scoreboard: compare every transferred word, and hold checks under backpressure.
    always @(negedge clk80) begin
        if (reset) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("hold_valid", 16'(dout_valid), 16'd1);
                chk("hold_data", dout, hold_w);
            end
            if (dout_valid && dout_ready) begin
                n_pop++;
                n_assert++;
                assert (exp_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL unexpected_word: observed %h expected none", dout);
                end
                if (exp_q.size() != 0) chk("dout_word", dout, exp_q.pop_front());
                hold_v = 1'b0;
            end else begin
                hold_v = dout_valid;
                hold_w = dout;
            end
        end
    end

    initial begin
        int pop_base;
        reset      = 1'b1;
        running    = 1'b0;
        write      = 1'b0;
        data       = 16'd0;
        err        = 2'b00;
        dout_ready = 1'b1;
        repeat (3) @(posedge clk80);
        #1;
        chk("rst_valid", 16'(dout_valid), 16'd0);
        chk("rst_dout", dout, 16'd0);
        chk("rst_overflow", 16'(overflow), 16'd0);
        chk("rst_evt_count", evt_count, 16'd0);
        chk("rst_state", 16'(state_dbg), 16'd0);
        reset = 1'b0;
        idle(2);

        // Single event: four words then trailer with count 4.
        begin_event();
        for (int i = 0; i < 4; i++) write_word(16'h8001 + 16'(i), 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'd0, 2'b00);
        expect_trailer(16'h6004);
        idle(3);
        wait_drain("single_drain", 40);
        chk("single_evt_count", evt_count, 16'd1);
        chk("single_overflow", 16'(overflow), 16'd0);

        // Write on the fall cycle belongs to the closing event.
        begin_event();
        step(1'b1, 1'b0, 16'd0, 2'b00);
        write_word(16'h8011, 1'b1);
        step(1'b1, 1'b0, 16'd0, 2'b00);
        exp_q.push_back(16'h8012);
        step(1'b0, 1'b1, 16'h8012, 2'b00);
        expect_trailer(16'h6002);
        idle(3);
        wait_drain("fall_write_drain", 40);
        chk("fall_write_evt_count", evt_count, 16'd2);

        // Error flags accumulate, including the fall cycle, and clear per event.
        begin_event();
        exp_q.push_back(16'h8021);
        step(1'b1, 1'b1, 16'h8021, 2'b01);
        step(1'b1, 1'b0, 16'd0, 2'b00);
        step(1'b0, 1'b0, 16'd0, 2'b10);
        expect_trailer(16'h6601);
        idle(3);
        begin_event();
        write_word(16'h8022, 1'b1);
        step(1'b1, 1'b0, 16'd0, 2'b00);
        expect_trailer(16'h6001);
        idle(3);
        wait_drain("err_drain", 40);
        chk("err_evt_count", evt_count, 16'd4);

        // Backpressure overflow: only the unreserved slots take data.
        dout_ready = 1'b0;
        begin_event();
        for (int i = 0; i < 40; i++) write_word(16'h8100 + 16'(i), (i < KEEP) ? 1'b1 : 1'b0);
        step(1'b0, 1'b0, 16'd0, 2'b00);
        expect_trailer(16'h6828);
        idle(4);
        chk("ovf_overflow", 16'(overflow), 16'd1);
        chk("ovf_evt_count", evt_count, 16'd5);
        chk("ovf_valid", 16'(dout_valid), 16'd1);
        pop_base   = n_pop;
        dout_ready = 1'b1;
        wait_drain("ovf_drain", 100);
        idle(3);
        chk("ovf_total_words", 16'(n_pop - pop_base), 16'd32);
        chk("ovf_valid_empty", 16'(dout_valid), 16'd0);

        // Word counter saturates at 511.
        begin_event();
        for (int i = 0; i < 520; i++) write_word(16'h4000 | 16'(i), 1'b1);
        step(1'b0, 1'b0, 16'd0, 2'b00);
        expect_trailer(16'h61FF);
        idle(3);
        wait_drain("sat_drain", 100);
        chk("sat_evt_count", evt_count, 16'd6);

        // Reset mid-event discards the partial event.
        dout_ready = 1'b0;
        begin_event();
        for (int i = 0; i < 3; i++) write_word(16'h8201 + 16'(i), 1'b0);
        reset   = 1'b1;
        running = 1'b0;
        write   = 1'b0;
        #1;
        chk("midrst_valid", 16'(dout_valid), 16'd0);
        chk("midrst_evt_count", evt_count, 16'd0);
        chk("midrst_overflow", 16'(overflow), 16'd0);
        chk("midrst_state", 16'(state_dbg), 16'd0);
        @(posedge clk80);
        #1;
        reset      = 1'b0;
        dout_ready = 1'b1;
        idle(2);
        begin_event();
        write_word(16'h8301, 1'b1);
        write_word(16'h8302, 1'b1);
        step(1'b1, 1'b0, 16'd0, 2'b00);
        expect_trailer(16'h6002);
        idle(3);
        wait_drain("post_rst_drain", 40);
        chk("post_rst_evt_count", evt_count, 16'd1);

`ifdef PACKER_TIMESTAMP_EN
        // Timestamp word precedes the trailer; two slots stay reserved.
        dout_ready = 1'b0;
        for (int i = 0; i < 5000 && ts_cyc[11:0] != 12'h123; i++) idle(1);
        chk("ts_align", 16'(ts_cyc[11:0]), 16'h0123);
        begin_event();
        for (int i = 0; i < 31; i++) write_word(16'h8400 + 16'(i), (i < 30) ? 1'b1 : 1'b0);
        step(1'b0, 1'b0, 16'd0, 2'b00);
        expect_trailer(16'h681F);
        idle(4);
        chk("ts_overflow", 16'(overflow), 16'd1);
        dout_ready = 1'b1;
        wait_drain("ts_drain", 100);
`endif

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
